// File: rtl/cpu_stage_sequencer.sv
// cpu_stage_sequencer
// Multi-cycle stage controller for the Rv32H core. It runs one instruction
// at a time through fetch, decode, execute, an optional memory stage and
// writeback. Each stage gets a one-cycle start pulse, and the sequencer then
// waits for that stage's one-cycle done pulse. It also counts retired
// instructions, and a watchdog latches FAULT if a stage hangs.
//
// Ports
//   i_clock, i_reset    rising-edge clock; asynchronous active-low reset
//   i_enable            run request (sampled in IDLE and on writeback done)
//   o_fetch/i_fetched, o_decode/i_decoded, o_execute/i_executed,
//   o_memory/i_memory_done, o_writeback/i_written_back
//                       start pulse out / done pulse in, per stage
//   i_mem_required      qualifies i_executed: route through the memory stage
//   o_retired           one-cycle pulse per retired instruction
//   o_retire_count      retired-instruction counter (wraps silently)
//   o_state             current state encoding
//   o_fault             sticky watchdog fault flag
module cpu_stage_sequencer #(
    parameter int TIMEOUT      = 1024,
    parameter int RETIRE_WIDTH = 32
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_enable,
    output logic                    o_fetch,
    input  logic                    i_fetched,
    output logic                    o_decode,
    input  logic                    i_decoded,
    output logic                    o_execute,
    input  logic                    i_executed,
    input  logic                    i_mem_required,
    output logic                    o_memory,
    input  logic                    i_memory_done,
    output logic                    o_writeback,
    input  logic                    i_written_back,
    output logic                    o_retired,
    output logic [RETIRE_WIDTH-1:0] o_retire_count,
    output logic [2:0]              o_state,
    output logic                    o_fault
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_MEMORY    = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_FAULT     = 3'd6
    } state_t;

    localparam int              WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    state_t                  state_r;
    state_t                  next_state_s;
    logic                    entry_r;       // high during the first cycle of a state
    logic [WD_W-1:0]         watchdog_r;
    logic                    fetch_r, decode_r, execute_r, memory_r, writeback_r;
    logic                    retired_r;
    logic                    fault_r;
    logic [RETIRE_WIDTH-1:0] retire_count_r;
    logic                    stage_done_s;
    logic                    done_ok_s;
    logic                    expired_s;
    logic                    retire_s;

    // True when the registered state moves into stage s on this edge.
    function automatic logic entering(input state_t cur, input state_t nxt, input state_t s);
        return (nxt == s) && (cur != s);
    endfunction

    // Select the done input that belongs to the current state.
    always_comb begin
        stage_done_s = 1'b0;
        case (state_r)
            ST_FETCH:     stage_done_s = i_fetched;
            ST_DECODE:    stage_done_s = i_decoded;
            ST_EXECUTE:   stage_done_s = i_executed;
            ST_MEMORY:    stage_done_s = i_memory_done;
            ST_WRITEBACK: stage_done_s = i_written_back;
            default:      stage_done_s = 1'b0;
        endcase
    end

    // Next-state logic. A done pulse overlapping the start pulse is ignored,
    // and a done pulse in the last watchdog cycle still wins over FAULT.
    always_comb begin
        next_state_s = state_r;
        done_ok_s    = stage_done_s && !entry_r;
        expired_s    = (watchdog_r == WD_LAST);
        retire_s     = (state_r == ST_WRITEBACK) && done_ok_s;
        case (state_r)
            ST_IDLE: begin
                if (i_enable) next_state_s = ST_FETCH;
                else          next_state_s = ST_IDLE;
            end
            ST_FETCH: begin
                if (done_ok_s)      next_state_s = ST_DECODE;
                else if (expired_s) next_state_s = ST_FAULT;
                else                next_state_s = ST_FETCH;
            end
            ST_DECODE: begin
                if (done_ok_s)      next_state_s = ST_EXECUTE;
                else if (expired_s) next_state_s = ST_FAULT;
                else                next_state_s = ST_DECODE;
            end
            ST_EXECUTE: begin
                if (done_ok_s)      next_state_s = i_mem_required ? ST_MEMORY : ST_WRITEBACK;
                else if (expired_s) next_state_s = ST_FAULT;
                else                next_state_s = ST_EXECUTE;
            end
            ST_MEMORY: begin
                if (done_ok_s)      next_state_s = ST_WRITEBACK;
                else if (expired_s) next_state_s = ST_FAULT;
                else                next_state_s = ST_MEMORY;
            end
            ST_WRITEBACK: begin
                if (done_ok_s)      next_state_s = i_enable ? ST_FETCH : ST_IDLE;
                else if (expired_s) next_state_s = ST_FAULT;
                else                next_state_s = ST_WRITEBACK;
            end
            ST_FAULT: next_state_s = ST_FAULT;
            default:  next_state_s = ST_FAULT;  // unused encoding 7 is treated as a fault
        endcase
    end

    // State, watchdog, registered pulses and retire counter.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_r        <= ST_IDLE;
            entry_r        <= 1'b0;
            watchdog_r     <= {WD_W{1'b0}};
            fetch_r        <= 1'b0;
            decode_r       <= 1'b0;
            execute_r      <= 1'b0;
            memory_r       <= 1'b0;
            writeback_r    <= 1'b0;
            retired_r      <= 1'b0;
            fault_r        <= 1'b0;
            retire_count_r <= {RETIRE_WIDTH{1'b0}};
        end else begin
            state_r     <= next_state_s;
            entry_r     <= (next_state_s != state_r);
            fetch_r     <= entering(state_r, next_state_s, ST_FETCH);
            decode_r    <= entering(state_r, next_state_s, ST_DECODE);
            execute_r   <= entering(state_r, next_state_s, ST_EXECUTE);
            memory_r    <= entering(state_r, next_state_s, ST_MEMORY);
            writeback_r <= entering(state_r, next_state_s, ST_WRITEBACK);
            retired_r   <= retire_s;
            fault_r     <= (next_state_s == ST_FAULT);
            // Watchdog restarts on every state entry and idles in IDLE/FAULT.
            if ((next_state_s != state_r) || (next_state_s == ST_IDLE) || (next_state_s == ST_FAULT)) begin
                watchdog_r <= {WD_W{1'b0}};
            end else begin
                watchdog_r <= watchdog_r + WD_W'(1);
            end
            if (retire_s) begin
                retire_count_r <= retire_count_r + RETIRE_WIDTH'(1);
            end else begin
                retire_count_r <= retire_count_r;
            end
        end
    end

    assign o_fetch        = fetch_r;
    assign o_decode       = decode_r;
    assign o_execute      = execute_r;
    assign o_memory       = memory_r;
    assign o_writeback    = writeback_r;
    assign o_retired      = retired_r;
    assign o_fault        = fault_r;
    assign o_retire_count = retire_count_r;
    assign o_state        = 3'(state_r);

endmodule

// File: tb/tb_cpu_stage_sequencer.sv
// Scoreboard bench for cpu_stage_sequencer (TIMEOUT=16, RETIRE_WIDTH=4).
// The stimulus pushes the expected output events (cycle, pulses, state,
// count). A negedge monitor pops one event each time the DUT shows a pulse.
module tb_cpu_stage_sequencer;

    localparam int TO = 16;

    localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DEC = 3'd2, S_EXE = 3'd3,
                           S_MEM = 3'd4, S_WB = 3'd5, S_FAULT = 3'd6;
    // pulse vector: {fault_rise, retired, writeback, memory, execute, decode, fetch}
    localparam logic [6:0] P_FETCH = 7'h01, P_DEC = 7'h02, P_EXE = 7'h04, P_MEM = 7'h08,
                           P_WB = 7'h10, P_RET = 7'h20, P_FLT = 7'h40;

    typedef struct {
        int         cyc;
        logic [6:0] pulses;
        logic [2:0] state;
        logic [3:0] count;
    } exp_t;

    logic       i_clock = 1'b0;
    logic       i_reset = 1'b0;
    logic       i_enable = 1'b0;
    logic       i_fetched = 1'b0, i_decoded = 1'b0, i_executed = 1'b0, i_mem_required = 1'b0;
    logic       i_memory_done = 1'b0, i_written_back = 1'b0;
    logic       o_fetch, o_decode, o_execute, o_memory, o_writeback, o_retired, o_fault;
    logic [3:0] o_retire_count;
    logic [2:0] o_state;

    int         cyc = 0;
    int         tests = 0;
    int         fails = 0;
    exp_t       exp_q[$];
    logic [3:0] exp_count = 4'd0;
    bit         pend_ret = 1'b0;
    logic       prev_fault = 1'b0;

    cpu_stage_sequencer #(.TIMEOUT(TO), .RETIRE_WIDTH(4)) dut (
        .i_clock(i_clock), .i_reset(i_reset), .i_enable(i_enable),
        .o_fetch(o_fetch), .i_fetched(i_fetched),
        .o_decode(o_decode), .i_decoded(i_decoded),
        .o_execute(o_execute), .i_executed(i_executed), .i_mem_required(i_mem_required),
        .o_memory(o_memory), .i_memory_done(i_memory_done),
        .o_writeback(o_writeback), .i_written_back(i_written_back),
        .o_retired(o_retired), .o_retire_count(o_retire_count),
        .o_state(o_state), .o_fault(o_fault)
    );

    always #5 i_clock = ~i_clock;

    always @(posedge i_clock) cyc <= cyc + 1;

    // Monitor: pop and compare whenever the DUT presents a pulse.
    always @(negedge i_clock) begin
        logic [6:0] obs;
        exp_t       e;
        obs = {o_fault & ~prev_fault, o_retired, o_writeback, o_memory, o_execute, o_decode, o_fetch};
        prev_fault = o_fault;
        if (obs != 7'h00) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL event: unexpected pulses=%h state=%0d count=%0d at cycle %0d, none required",
                         obs, o_state, o_retire_count, cyc);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc != cyc || e.pulses != obs || e.state != o_state || e.count != o_retire_count) begin
                    fails++;
                    $display("FAIL event: got cyc=%0d pulses=%h state=%0d count=%0d, required cyc=%0d pulses=%h state=%0d count=%0d",
                             cyc, obs, o_state, o_retire_count, e.cyc, e.pulses, e.state, e.count);
                end
            end
        end
    end

    task automatic tick();
        @(posedge i_clock);
        #1;
    endtask

    task automatic push_exp(input logic [6:0] p, input logic [2:0] s);
        exp_t e;
        e.cyc = cyc; e.pulses = p; e.state = s; e.count = exp_count;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Runs one instruction; the current cycle must be the o_fetch cycle.
    task automatic run_instr(input bit mem, input bit stop, input bit spur);
        push_exp(P_FETCH | (pend_ret ? P_RET : 7'h00), S_FETCH);
        pend_ret = 1'b0;
        tick(); i_fetched = 1'b1;
        tick(); i_fetched = 1'b0;
        push_exp(P_DEC, S_DEC);
        if (spur) i_decoded = 1'b1;          // overlaps o_decode: ignored
        if (stop) i_enable = 1'b0;
        tick(); i_decoded = 1'b1;
        tick(); i_decoded = 1'b0;
        push_exp(P_EXE, S_EXE);
        if (spur) begin                      // out-of-state and same-cycle pulses
            i_decoded = 1'b1; i_written_back = 1'b1; i_executed = 1'b1; i_mem_required = 1'b1;
        end
        tick(); i_decoded = 1'b0; i_written_back = 1'b0;
        i_executed = 1'b1; i_mem_required = mem;
        tick(); i_executed = 1'b0; i_mem_required = 1'b0;
        if (mem) begin
            push_exp(P_MEM, S_MEM);
            tick(); i_memory_done = 1'b1;
            tick(); i_memory_done = 1'b0;
        end
        push_exp(P_WB, S_WB);
        tick(); i_written_back = 1'b1;
        tick(); i_written_back = 1'b0;
        exp_count = exp_count + 4'd1;
        if (i_enable) pend_ret = 1'b1;
        else          push_exp(P_RET, S_IDLE);
    endtask

    initial begin
        // Reset state
        tick(); tick();
        chk("reset_state", {29'd0, o_state}, 32'd0);
        chk("reset_count", {28'd0, o_retire_count}, 32'd0);
        chk("reset_outs", {25'd0, o_fetch, o_decode, o_execute, o_memory, o_writeback, o_retired, o_fault}, 32'd0);
        i_reset = 1'b1;
        tick();
        chk("idle_no_enable", {29'd0, o_state}, 32'd0);

        // Basic runs, memory path, spurious pulses, stop request
        i_enable = 1'b1;
        tick();
        run_instr(1'b0, 1'b0, 1'b0);
        run_instr(1'b0, 1'b0, 1'b0);
        run_instr(1'b1, 1'b0, 1'b0);
        run_instr(1'b0, 1'b0, 1'b1);
        run_instr(1'b0, 1'b1, 1'b0);
        repeat (5) tick();
        chk("stop_idle_state", {29'd0, o_state}, 32'd0);
        chk("stop_count", {28'd0, o_retire_count}, 32'd5);

        // Restart, then retire 12 more (17 total) so the 4-bit count wraps to 1
        i_enable = 1'b1;
        tick();
        for (int i = 0; i < 12; i++) run_instr(i[0], i == 11, 1'b0);
        repeat (3) tick();
        chk("wrap_count", {28'd0, o_retire_count}, 32'd1);

        // Reset mid-EXECUTE clears everything without a clock edge
        i_enable = 1'b1;
        tick();
        push_exp(P_FETCH, S_FETCH);
        i_enable = 1'b0;
        tick(); i_fetched = 1'b1;
        tick(); i_fetched = 1'b0;
        push_exp(P_DEC, S_DEC);
        tick(); i_decoded = 1'b1;
        tick(); i_decoded = 1'b0;
        chk("pre_reset_execute", {31'd0, o_execute}, 32'd1);
        #2 i_reset = 1'b0;
        #1;
        chk("async_reset_state", {29'd0, o_state}, 32'd0);
        chk("async_reset_count", {28'd0, o_retire_count}, 32'd0);
        chk("async_reset_pulse", {31'd0, o_execute}, 32'd0);
        exp_count = 4'd0;
        tick(); i_reset = 1'b1;
        tick();

        // Watchdog: fetch done on the last allowed cycle wins, decode then hangs
        i_enable = 1'b1;
        tick();
        push_exp(P_FETCH, S_FETCH);
        repeat (TO - 1) tick();
        i_fetched = 1'b1;
        tick(); i_fetched = 1'b0;
        push_exp(P_DEC, S_DEC);
        repeat (TO) tick();
        push_exp(P_FLT, S_FAULT);
        tick();
        i_fetched = 1'b1; i_decoded = 1'b1; i_executed = 1'b1; i_memory_done = 1'b1; i_written_back = 1'b1;
        repeat (4) tick();
        i_fetched = 1'b0; i_decoded = 1'b0; i_executed = 1'b0; i_memory_done = 1'b0; i_written_back = 1'b0;
        tick();
        chk("fault_state", {29'd0, o_state}, 32'd6);
        chk("fault_flag", {31'd0, o_fault}, 32'd1);
        chk("fault_count", {28'd0, o_retire_count}, 32'd0);
        i_enable = 1'b0;
        #2 i_reset = 1'b0;
        #1;
        chk("fault_clear_flag", {31'd0, o_fault}, 32'd0);
        chk("fault_clear_state", {29'd0, o_state}, 32'd0);
        tick(); i_reset = 1'b1;
        repeat (3) tick();

        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
